// File: rtl/p2s_pkg.sv
// Shared types and constants for the parallel-to-serial converter.
// Holds the FSM state enum, default width and detector pattern.
package p2s_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } p2s_state_t;

    localparam int          DEF_WIDTH = 12;
    localparam logic [11:0] DET_SEQ   = 12'hEDB;

endpackage

// File: rtl/p2s_hold_reg.sv
// One-word holding buffer in front of the shifter.
// Ports: clk, reset, data_i/valid_i (producer), ready_o,
//        drain (shifter takes the word), buf_vld, buf_data.
module p2s_hold_reg
    import p2s_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic             drain,
    output logic             ready_o,
    output logic             buf_vld,
    output logic [WIDTH-1:0] buf_data
);

    logic take;

    // Gating with reset keeps a word from being taken
    // on the same edge that reset is released.
    assign ready_o = !buf_vld && !reset;
    assign take    = valid_i && ready_o;

    // take needs buf_vld=0 and drain needs buf_vld=1,
    // so the two never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_vld  <= 1'b0;
            buf_data <= '0;
        end else if (take) begin
            buf_vld  <= 1'b1;
            buf_data <= data_i;
        end else if (drain) begin
            buf_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/par_to_ser.sv
// Parallel-to-serial converter, LSB first, gapless streaming.
// Ports: clk, reset, data_i/valid_i/ready_o (word in),
//        serial_o/serial_vld_o/sof_o/par_o (bit out).
// Macro P2S_PARITY_EN adds an even-parity bit per word.
module par_to_ser
    import p2s_pkg::*;
#(
    parameter int   WIDTH    = DEF_WIDTH,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             serial_o,
    output logic             serial_vld_o,
    output logic             sof_o,
    output logic             par_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    p2s_state_t       state, state_nx;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] buf_data;
    logic [CW-1:0]    cnt;
    logic             buf_vld;
    logic             last;
    logic             free;
    logic             load;
`ifdef P2S_PARITY_EN
    logic             par_q;
`endif

    p2s_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .drain    (load),
        .ready_o  (ready_o),
        .buf_vld  (buf_vld),
        .buf_data (buf_data)
    );

    assign last = (state == SHIFT) && (cnt == LAST);

    // Free = this edge ends the current word.
`ifdef P2S_PARITY_EN
    assign free = (state == IDLE) || (state == PARITY);
`else
    assign free = (state == IDLE) || last;
`endif
    assign load = free && buf_vld;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (buf_vld) state_nx = SHIFT;
            end
            SHIFT: begin
                if (last) begin
`ifdef P2S_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = buf_vld ? SHIFT : IDLE;
`endif
                end
            end
            PARITY: begin
                state_nx = buf_vld ? SHIFT : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        serial_o     = IDLE_BIT;
        serial_vld_o = 1'b0;
        sof_o        = 1'b0;
        par_o        = 1'b0;
        unique case (state)
            SHIFT: begin
                serial_o     = sr[0];
                serial_vld_o = 1'b1;
                sof_o        = (cnt == '0);
            end
            PARITY: begin
`ifdef P2S_PARITY_EN
                serial_o     = par_q;
                serial_vld_o = 1'b1;
                par_o        = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                sr  <= buf_data;
                cnt <= '0;
            end else if (state == SHIFT) begin
                sr <= sr >> 1;
                // Hold at the last index so cnt never reaches WIDTH.
                if (!last) cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef P2S_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= ^buf_data;
        end
    end
`endif

endmodule
